// File: rtl/fp_accum_pkg.sv
// Shared types and constants for the streaming binary32 accumulator.
// Optional build macro consumed by fp_accum: FP_ACCUM_FTZ_EN.
package fp_accum_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [7:0]      FP_EXP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_accum_if.sv
// Stream-in / result-out bundle of the binary32 accumulator.
// master = producer/consumer side, slave = accumulator side.
interface fp_accum_if
  import fp_accum_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [FP_W-1:0]  out_sum;
  logic             out_ovf;
  logic             out_nan;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_nan, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_nan, out_count
  );
endinterface

// File: rtl/fadd.sv
// Combinational IEEE-754 binary32 adder, round-to-nearest-even.
// Any NaN input or Inf + -Inf gives canonical NaN 7FC00000; finite overflow
// saturates to signed Inf and raises ovf. Exact cancellation yields +0.
module fadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic        ovf
);

  // Leading zeros of a 27-bit significand (hidden bit at position 26).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  logic        sx, sy;
  logic [7:0]  ea, eb, ex, ey, d;
  logic [26:0] ma, mb, mx, my, my_sh, norm;
  logic [27:0] sum;
  logic [9:0]  e, e_m1;
  logic [4:0]  lz, sh;
  logic        sticky, up;
  logic [24:0] mr;
  logic        a_nan, b_nan, a_inf, b_inf;

  // Align, add/subtract, normalise, round, then override for special operands.
  always_comb begin
    res    = 32'd0;
    ovf    = 1'b0;
    sx     = a[31];
    sy     = b[31];
    ea     = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb     = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma     = {a[30:23] != 8'd0, a[22:0], 3'b000};
    mb     = {b[30:23] != 8'd0, b[22:0], 3'b000};
    ex     = ea;
    ey     = eb;
    mx     = ma;
    my     = mb;
    my_sh  = 27'd0;
    sticky = 1'b0;
    sum    = 28'd0;
    norm   = 27'd0;
    e      = 10'd0;
    e_m1   = 10'd0;
    lz     = 5'd0;
    sh     = 5'd0;
    up     = 1'b0;
    mr     = 25'd0;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // Larger magnitude becomes x.
    if (a[30:0] < b[30:0]) begin
      sx = b[31]; sy = a[31];
      ex = eb;    ey = ea;
      mx = mb;    my = ma;
    end

    d = ex - ey;
    if (d >= 8'd27) begin
      my_sh  = 27'd0;
      sticky = |my;
    end else begin
      my_sh  = my >> d;
      sticky = |(my & ~({27{1'b1}} << d));
    end
    my_sh[0] = my_sh[0] | sticky;

    if (sx == sy) sum = {1'b0, mx} + {1'b0, my_sh};
    else          sum = {1'b0, mx} - {1'b0, my_sh};

    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = {2'b00, ex} + 10'd1;
    end else begin
      lz   = lzc27(sum[26:0]);
      e_m1 = {2'b00, ex} - 10'd1;
      sh   = ({5'd0, lz} > e_m1) ? e_m1[4:0] : lz;
      norm = sum[26:0] << sh;
      e    = {2'b00, ex} - {5'd0, sh};
    end

    up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr = {1'b0, norm[26:3]} + {24'd0, up};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'd1;
    end

    if (sum == 28'd0) begin
      res = (sx == sy) ? {sx, 31'd0} : 32'd0;
    end else if (mr[23] && (e >= 10'd255)) begin
      res = {sx, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else begin
      res = {sx, (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      res = 32'h7FC0_0000;
      ovf = 1'b0;
    end else if (a_inf) begin
      res = a;
      ovf = 1'b0;
    end else if (b_inf) begin
      res = b;
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Streaming binary32 packet accumulator wrapped around one fadd instance.
// Build macro FP_ACCUM_FTZ_EN: flush subnormal inputs to signed zero at capture.
module fp_accum
  import fp_accum_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  fp_accum_if.slave   bus
);

  localparam int DATA_W = FP_W;

  state_t             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               take;
  logic               done;

  logic [DATA_W-1:0]  data_p0;
  logic               vld_p0;

  logic [DATA_W-1:0]  acc_p1;
  logic               ovf_p1;
  logic               nan_p1;
  logic [CNT_W-1:0]   cnt_p1;

  logic [DATA_W-1:0]  sum_res;
  logic               sum_ovf;

  // Input conditioning: optional flush-to-zero of subnormal operands.
  function automatic logic [DATA_W-1:0] ftz(input logic [DATA_W-1:0] x);
`ifdef FP_ACCUM_FTZ_EN
    if ((x[30:23] == 8'd0) && (x[22:0] != 23'd0)) return {x[31], 31'd0};
    else                                          return x;
`else
    return x;
`endif
  endfunction

  // Beat counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign take = bus.in_valid && in_ready_q;
  assign done = out_valid_q && bus.out_ready;

  // Packet control: ready drops once the last beat is taken, result held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (take) begin
            if (bus.in_last) begin
              state      <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state      <= ACC;
            end
          end
        end
        DRAIN: begin
          state       <= HOLD;
          out_valid_q <= 1'b1;
        end
        HOLD: begin
          if (done) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: operand register valid flag.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= take;
  end

  // Stage p0: operand register data.
  always_ff @(posedge clk) begin
    if (take) data_p0 <= ftz(bus.in_data);
  end

  // Stage p1: fold operand into running sum and sticky flags; cleared on result hand-off.
  always_ff @(posedge clk) begin
    if (rst || done) begin
      acc_p1 <= FP_POS_ZERO;
      ovf_p1 <= 1'b0;
      nan_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else if (vld_p0) begin
      acc_p1 <= sum_res;
      ovf_p1 <= ovf_p1 | sum_ovf;
      nan_p1 <= nan_p1 | fp_is_nan(sum_res);
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  fadd u_fadd (
    .a   (acc_p1),
    .b   (data_p0),
    .res (sum_res),
    .ovf (sum_ovf)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_p1;
  assign bus.out_ovf   = ovf_p1;
  assign bus.out_nan   = nan_p1;
  assign bus.out_count = cnt_p1;

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: hand-computed packet sums, flags, counts,
// back-pressure, mid-packet reset and counter saturation (narrow counter).
module tb_fp_accum;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_accum_if #(.CNT_W(CNT_W)) bus ();

  fp_accum #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_sum"},       bus.out_sum,        32'd0);
    chk({tag, "_ovf"},       32'(bus.out_ovf),   32'd0);
    chk({tag, "_nan"},       32'(bus.out_nan),   32'd0);
    chk({tag, "_count"},     32'(bus.out_count), 32'd0);
  endtask

  // Present one beat from a negedge and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic l);
    int k;
    k = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait (bounded) for the result, compare it, and let the handshake edge pass.
  task automatic expect_res(input string tag, input logic [31:0] s, input logic o,
                            input logic n, input logic [CNT_W-1:0] c);
    int k;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   bus.out_sum,        s);
    chk({tag, "_ovf"},   32'(bus.out_ovf),   32'(o));
    chk({tag, "_nan"},   32'(bus.out_nan),   32'(n));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int k;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("rst");

    // 1.0 + 2.0 + 0.5 = 3.5, with latency check
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h3F00_0000, 1'b1);
    @(negedge clk);
    chk("p1_valid_e0", 32'(bus.out_valid), 32'd0);
    chk("p1_drain_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("p1_valid_e1", 32'(bus.out_valid), 32'd1);
    expect_res("p1", 32'h4060_0000, 1'b0, 1'b0, 4'd3);

    // exact cancellation
    send(32'h3F80_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    expect_res("cancel", 32'h0000_0000, 1'b0, 1'b0, 4'd2);

    // overflow to +Inf
    send(32'h7F7F_FFFF, 1'b0);
    send(32'h7F7F_FFFF, 1'b1);
    expect_res("ovf", 32'h7F80_0000, 1'b1, 1'b0, 4'd2);

    // NaN input, then flags cleared for the next packet
    send(32'h7FC0_0000, 1'b1);
    expect_res("nan", 32'h7FC0_0000, 1'b0, 1'b1, 4'd1);
    send(32'h3F80_0000, 1'b1);
    expect_res("after_nan", 32'h3F80_0000, 1'b0, 1'b0, 4'd1);

    // +Inf + -Inf gives NaN without overflow
    send(32'h7F80_0000, 1'b0);
    send(32'hFF80_0000, 1'b1);
    expect_res("inf_inf", 32'h7FC0_0000, 1'b0, 1'b1, 4'd2);

    // -0 onto the +0 seed stays +0
    send(32'h8000_0000, 1'b1);
    expect_res("negzero", 32'h0000_0000, 1'b0, 1'b0, 4'd1);

    // back-pressure in HOLD with a beat waiting
    bus.out_ready = 1'b0;
    send(32'h4000_0000, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F80_0000;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_sum",   bus.out_sum,        32'h4000_0000);
      chk("stall_count", 32'(bus.out_count), 32'd1);
      chk("stall_rdy",   32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    expect_res("stall", 32'h4000_0000, 1'b0, 1'b0, 4'd1);

    // reset in the middle of a packet
    send(32'h4040_0000, 1'b0);
    send(32'h3F80_0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b1);
    expect_res("post_rst", 32'h4000_0000, 1'b0, 1'b0, 4'd2);

    // 17 beats of 1.0: sum 17.0, counter saturates at 15
    for (int i = 0; i < 16; i++) send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b1);
    expect_res("sat", 32'h4188_0000, 1'b0, 1'b0, 4'd15);

    // smallest subnormal
    send(32'h0000_0001, 1'b1);
`ifdef FP_ACCUM_FTZ_EN
    expect_res("subn", 32'h0000_0000, 1'b0, 1'b0, 4'd1);
`else
    expect_res("subn", 32'h0000_0001, 1'b0, 1'b0, 4'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
